hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core: decides each cycle whether the instruction in ID issues into ID_EXE or is replaced by a bubble, and drives the matching hold/flush controls on PC and IF_ID. It covers three cases: load-use hazards, structural/data hazards on the multi-cycle multiply/divide unit (HI/LO), and wrong-path flush on a taken branch or jump resolved in EXE. Its `out_Stall_Or_Not` output drives the `Stall_Or_Not` input of the ID_EXE register directly.

---
 rtl/hazard_stall_controller_if.sv | 55 +++++
 rtl/hazard_stall_controller.sv | 93 +++++++++
 tb/tb_hazard_stall_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Hazard controller bundle: ID/EXE hazard
// inputs and pipeline hold/flush controls.
interface hazard_stall_controller_if;
  logic [4:0]  in_IF_ID_Rs_Address;
  logic [4:0]  in_IF_ID_Rt_Address;
  logic        in_Control_Unit_Uses_Rt;
  logic        in_Control_Unit_Is_MulDiv;
  logic        in_Control_Unit_Reads_HiLo;
  logic        in_ID_EXE_Mem_Read;
  logic [4:0]  in_ID_EXE_Rt_Address;
  logic        in_EXE_Branch_Taken;
  logic        out_Stall_Or_Not;
  logic        out_PC_Hold;
  logic        out_IF_ID_Hold;
  logic        out_IF_ID_Flush;
  logic        out_MulDiv_Busy;
  logic [7:0]  out_MulDiv_Count;
  logic [15:0] out_Stall_Count;

  modport master (
    output in_IF_ID_Rs_Address,
    output in_IF_ID_Rt_Address,
    output in_Control_Unit_Uses_Rt,
    output in_Control_Unit_Is_MulDiv,
    output in_Control_Unit_Reads_HiLo,
    output in_ID_EXE_Mem_Read,
    output in_ID_EXE_Rt_Address,
    output in_EXE_Branch_Taken,
    input  out_Stall_Or_Not,
    input  out_PC_Hold,
    input  out_IF_ID_Hold,
    input  out_IF_ID_Flush,
    input  out_MulDiv_Busy,
    input  out_MulDiv_Count,
    input  out_Stall_Count
  );

  modport slave (
    input  in_IF_ID_Rs_Address,
    input  in_IF_ID_Rt_Address,
    input  in_Control_Unit_Uses_Rt,
    input  in_Control_Unit_Is_MulDiv,
    input  in_Control_Unit_Reads_HiLo,
    input  in_ID_EXE_Mem_Read,
    input  in_ID_EXE_Rt_Address,
    input  in_EXE_Branch_Taken,
    output out_Stall_Or_Not,
    output out_PC_Hold,
    output out_IF_ID_Hold,
    output out_IF_ID_Flush,
    output out_MulDiv_Busy,
    output out_MulDiv_Count,
    output out_Stall_Count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use, HI/LO and branch-flush sequencing
// for the 5-stage core; state moves on negedge.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  hazard_stall_controller_if.slave    bus
);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] scnt_q;
  logic        lu, md, fl;
  logic        stall, hz;

  // Hazard detection from current ID/EXE contents
  always_comb begin
    lu = bus.in_ID_EXE_Mem_Read
      && (bus.in_ID_EXE_Rt_Address != 5'd0)
      && ((bus.in_ID_EXE_Rt_Address
           == bus.in_IF_ID_Rs_Address)
       || (bus.in_Control_Unit_Uses_Rt
           && bus.in_ID_EXE_Rt_Address
              == bus.in_IF_ID_Rt_Address));
    md = (state_q == MD_BUSY)
      && (bus.in_Control_Unit_Reads_HiLo
       || bus.in_Control_Unit_Is_MulDiv);
    fl = bus.in_EXE_Branch_Taken;
    hz = lu || md;
  end

  // Pipeline controls; flush beats any hazard
  always_comb begin
    stall               = 1'b0;
    bus.out_PC_Hold     = 1'b0;
    bus.out_IF_ID_Hold  = 1'b0;
    bus.out_IF_ID_Flush = 1'b0;
    if (rst || fl) begin
      stall               = 1'b1;
      bus.out_IF_ID_Flush = 1'b1;
    end else if (hz) begin
      stall              = 1'b1;
      bus.out_PC_Hold    = 1'b1;
      bus.out_IF_ID_Hold = 1'b1;
    end
    bus.out_Stall_Or_Not = stall;
  end

  // Mult/div busy tracking; only an issued op starts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.in_Control_Unit_Is_MulDiv
            && !stall) begin
          state_d = MD_BUSY;
          cnt_d   = 8'(MULDIV_CYCLES);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, busy count and saturating stall counter
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      scnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hz && !fl && scnt_q != 16'hFFFF)
        scnt_q <= scnt_q + 16'd1;
    end
  end

  assign bus.out_MulDiv_Busy  = (state_q == MD_BUSY);
  assign bus.out_MulDiv_Count = cnt_q;
  assign bus.out_Stall_Count  = scnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller:
// load-use, HI/LO busy, flush, reset, saturation.
module tb_hazard_stall_controller;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_stall_controller_if b ();
  hazard_stall_controller_if b1 ();

  hazard_stall_controller #(
    .MULDIV_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  hazard_stall_controller #(
    .MULDIV_CYCLES(1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  // expected {stall, pc_hold, ifid_hold, flush}
  task automatic ctl(
    input string      tag,
    input logic [3:0] e
  );
    pos();
    chk(tag,
        {12'd0, b.out_Stall_Or_Not,
         b.out_PC_Hold, b.out_IF_ID_Hold,
         b.out_IF_ID_Flush},
        {12'd0, e});
  endtask

  task automatic idle();
    b.in_IF_ID_Rs_Address        = 5'd0;
    b.in_IF_ID_Rt_Address        = 5'd0;
    b.in_Control_Unit_Uses_Rt    = 1'b0;
    b.in_Control_Unit_Is_MulDiv  = 1'b0;
    b.in_Control_Unit_Reads_HiLo = 1'b0;
    b.in_ID_EXE_Mem_Read         = 1'b0;
    b.in_ID_EXE_Rt_Address       = 5'd0;
    b.in_EXE_Branch_Taken        = 1'b0;
  endtask

  task automatic set_lu();
    b.in_ID_EXE_Mem_Read   = 1'b1;
    b.in_ID_EXE_Rt_Address = 5'd5;
    b.in_IF_ID_Rs_Address  = 5'd5;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    b1.in_IF_ID_Rs_Address        = 5'd0;
    b1.in_IF_ID_Rt_Address        = 5'd0;
    b1.in_Control_Unit_Uses_Rt    = 1'b0;
    b1.in_Control_Unit_Is_MulDiv  = 1'b0;
    b1.in_Control_Unit_Reads_HiLo = 1'b0;
    b1.in_ID_EXE_Mem_Read         = 1'b0;
    b1.in_ID_EXE_Rt_Address       = 5'd0;
    b1.in_EXE_Branch_Taken        = 1'b0;

    for (int i = 0; i < 2; i++) begin
      ctl("rst_ctl", 4'b1001);
      adv();
      chk("rst_busy", 16'(b.out_MulDiv_Busy), 0);
      chk("rst_cnt", 16'(b.out_MulDiv_Count), 0);
      chk("rst_scnt", b.out_Stall_Count, 0);
    end
    rst = 1'b0;

    ctl("idle", 4'b0000);
    adv();

    set_lu();
    ctl("lu", 4'b1110);
    adv();
    chk("lu_scnt", b.out_Stall_Count, 1);
    b.in_ID_EXE_Mem_Read = 1'b0;
    ctl("lu_bubble", 4'b0000);
    adv();

    idle();
    b.in_ID_EXE_Mem_Read   = 1'b1;
    b.in_ID_EXE_Rt_Address = 5'd7;
    b.in_IF_ID_Rs_Address  = 5'd3;
    b.in_IF_ID_Rt_Address  = 5'd7;
    ctl("rt_unused", 4'b0000);
    adv();
    b.in_Control_Unit_Uses_Rt = 1'b1;
    ctl("rt_used", 4'b1110);
    adv();
    chk("rt_scnt", b.out_Stall_Count, 2);

    idle();
    b.in_ID_EXE_Mem_Read      = 1'b1;
    b.in_Control_Unit_Uses_Rt = 1'b1;
    ctl("lu_r0", 4'b0000);
    adv();
    chk("r0_scnt", b.out_Stall_Count, 2);

    idle();
    b.in_Control_Unit_Is_MulDiv = 1'b1;
    ctl("mult_iss", 4'b0000);
    adv();
    chk("md_busy", 16'(b.out_MulDiv_Busy), 1);
    chk("md_cnt4", 16'(b.out_MulDiv_Count), 4);
    idle();
    b.in_Control_Unit_Reads_HiLo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctl("mfhi_stall", 4'b1110);
      adv();
      chk("md_dec", 16'(b.out_MulDiv_Count),
          16'(3 - i));
    end
    chk("md_done", 16'(b.out_MulDiv_Busy), 0);
    ctl("mfhi_iss", 4'b0000);
    adv();
    chk("md_scnt", b.out_Stall_Count, 6);

    idle();
    b.in_Control_Unit_Is_MulDiv = 1'b1;
    ctl("mult2_iss", 4'b0000);
    adv();
    idle();
    ctl("add_busy", 4'b0000);
    adv();
    chk("add_dec", 16'(b.out_MulDiv_Count), 3);
    b.in_Control_Unit_Is_MulDiv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctl("mult3_stall", 4'b1110);
      adv();
      chk("m3_dec", 16'(b.out_MulDiv_Count),
          16'(2 - i));
    end
    ctl("mult3_iss", 4'b0000);
    adv();
    chk("m3_cnt", 16'(b.out_MulDiv_Count), 4);
    chk("m3_scnt", b.out_Stall_Count, 9);

    idle();
    b.in_Control_Unit_Reads_HiLo = 1'b1;
    b.in_EXE_Branch_Taken        = 1'b1;
    ctl("fl_busy", 4'b1001);
    adv();
    chk("fl_dec", 16'(b.out_MulDiv_Count), 3);
    chk("fl_scnt", b.out_Stall_Count, 9);
    idle();
    repeat (3) adv();
    chk("drain", 16'(b.out_MulDiv_Busy), 0);

    set_lu();
    b.in_Control_Unit_Is_MulDiv = 1'b1;
    b.in_EXE_Branch_Taken       = 1'b1;
    ctl("fl_all", 4'b1001);
    adv();
    chk("fl_scnt2", b.out_Stall_Count, 9);
    chk("fl_run", 16'(b.out_MulDiv_Busy), 0);
    chk("fl_cnt", 16'(b.out_MulDiv_Count), 0);

    idle();
    b.in_Control_Unit_Is_MulDiv = 1'b1;
    ctl("mult4_iss", 4'b0000);
    adv();
    idle();
    rst = 1'b1;
    ctl("rst_mid", 4'b1001);
    adv();
    rst = 1'b0;
    chk("rstm_cnt", 16'(b.out_MulDiv_Count), 0);
    chk("rstm_busy", 16'(b.out_MulDiv_Busy), 0);
    chk("rstm_scnt", b.out_Stall_Count, 0);

    b1.in_Control_Unit_Is_MulDiv = 1'b1;
    pos();
    chk("m1_iss", 16'(b1.out_Stall_Or_Not), 0);
    adv();
    chk("m1_cnt", 16'(b1.out_MulDiv_Count), 1);
    b1.in_Control_Unit_Is_MulDiv  = 1'b0;
    b1.in_Control_Unit_Reads_HiLo = 1'b1;
    pos();
    chk("m1_stall", 16'(b1.out_Stall_Or_Not), 1);
    adv();
    chk("m1_idle", 16'(b1.out_MulDiv_Busy), 0);
    pos();
    chk("m1_mfhi", 16'(b1.out_Stall_Or_Not), 0);
    adv();

    set_lu();
    repeat (65535) adv();
    chk("sat", b.out_Stall_Count, 16'hFFFF);
    repeat (5) adv();
    chk("sat_hold", b.out_Stall_Count, 16'hFFFF);
    ctl("sat_ctl", 4'b1110);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
